// File: rtl/serial2parallel.sv
// Receive-side deserializer: rebuilds N-bit words from a framed LSB-first bit
// stream and flags short, long and resynchronised frames on frame_err.
module serial2parallel #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d,
  input  logic          serial_start,
  input  logic          serial_end,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic          frame_err,
  output logic          busy,
  output logic [CW-1:0] bit_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] bit_count_q, bit_count_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    q_d         = q_q;
    q_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    bit_count_d = bit_count_q;

    case (state_q)
      IDLE, DRAIN: begin
        // A start marker always wins, so start+end together opens a new frame.
        if (serial_start) begin
          shift_d[0]  = d;
          bit_count_d = CW'(1);
          state_d     = SHIFT;
        end else if (serial_end) begin
          frame_err_d = (state_q == IDLE);
          state_d     = IDLE;
        end
      end
      SHIFT: begin
        if (serial_start) begin
          frame_err_d = 1'b1;
          shift_d[0]  = d;
          bit_count_d = CW'(1);
        end else begin
          for (int i = 0; i < N; i++) begin
            if (CW'(i) == bit_count_q) shift_d[i] = d;
          end
          if (serial_end) begin
            if (bit_count_q == CW'(N-1)) begin
              q_d       = shift_d;
              q_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            bit_count_d = '0;
            state_d     = IDLE;
          end else if (bit_count_q == CW'(N-1)) begin
            // Frame ran past N bits: report once, then swallow until its end.
            frame_err_d = 1'b1;
            bit_count_d = '0;
            state_d     = DRAIN;
          end else begin
            bit_count_d = bit_count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        bit_count_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Scoreboard bench for serial2parallel: a queue-based frame model predicts
// per-cycle status and q_valid/frame_err events; a monitor pops and compares.
module tb_serial2parallel;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          d = 1'b0;
  logic          serial_start = 1'b0;
  logic          serial_end = 1'b0;
  logic [N-1:0]  q;
  logic          q_valid;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] bit_count;

  always #5 clk = ~clk;

  serial2parallel #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .d(d), .serial_start(serial_start),
    .serial_end(serial_end), .q(q), .q_valid(q_valid),
    .frame_err(frame_err), .busy(busy), .bit_count(bit_count)
  );

  typedef struct packed {
    logic         is_valid;
    logic [N-1:0] data;
  } ev_t;

  typedef struct packed {
    logic [N-1:0]  q;
    logic          qv;
    logic          fe;
    logic          busy;
    logic [CW-1:0] bc;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: the frame is just the list of bits collected so far.
  bit           m_bits[$];
  bit           m_in_frame = 1'b0;
  bit           m_drain = 1'b0;
  logic [N-1:0] m_q = '0;

  function automatic logic [N-1:0] pack_bits();
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < m_bits.size() && i < N; i++)
      if (m_bits[i]) w = w | (N'(1) << i);
    return w;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic e, input logic dd);
    st_t st;
    ev_t ev;
    logic v;
    logic f;
    v = 1'b0;
    f = 1'b0;
    if (r) begin
      m_bits.delete(); m_in_frame = 1'b0; m_drain = 1'b0; m_q = '0;
    end else if (s) begin
      if (m_in_frame) f = 1'b1;
      m_bits.delete(); m_bits.push_back(dd);
      m_in_frame = 1'b1; m_drain = 1'b0;
    end else if (m_in_frame) begin
      m_bits.push_back(dd);
      if (e) begin
        if (m_bits.size() == N) begin m_q = pack_bits(); v = 1'b1; end
        else f = 1'b1;
        m_bits.delete(); m_in_frame = 1'b0;
      end else if (m_bits.size() == N) begin
        f = 1'b1; m_bits.delete(); m_in_frame = 1'b0; m_drain = 1'b1;
      end
    end else if (m_drain) begin
      if (e) m_drain = 1'b0;
    end else if (e) begin
      f = 1'b1;
    end
    if (v || f) begin
      ev.is_valid = v;
      ev.data     = v ? m_q : '0;
      ev_q.push_back(ev);
    end
    st.q    = m_q;
    st.qv   = v;
    st.fe   = f;
    st.busy = m_in_frame || m_drain;
    st.bc   = CW'(m_bits.size());
    st_q.push_back(st);
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic dd);
    if (r && !reset) begin
      @(negedge clk);
      #1;
    end
    reset = r; serial_start = s; serial_end = e; d = dd;
    @(posedge clk);
    model_step(r, s, e, dd);
    #1;
  endtask

  // end_at < 0 means no end marker inside these bits.
  task automatic send_bits(input logic [31:0] w, input int len, input int end_at);
    logic [31:0] t;
    for (int i = 0; i < len; i++) begin
      t = w >> i;
      drive(1'b0, i == 0, i == end_at, t[0]);
    end
  endtask

  st_t mon_exp;
  st_t mon_act;
  ev_t mon_ev;

  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      mon_exp = st_q.pop_front();
      mon_act = {q, q_valid, frame_err, busy, bit_count};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL status @%0t: got q=%h qv=%b fe=%b busy=%b bc=%0d, expected q=%h qv=%b fe=%b busy=%b bc=%0d",
                 $time, mon_act.q, mon_act.qv, mon_act.fe, mon_act.busy, mon_act.bc,
                 mon_exp.q, mon_exp.qv, mon_exp.fe, mon_exp.busy, mon_exp.bc);
      end
    end
    if (q_valid === 1'b1 || frame_err === 1'b1) begin
      vectors++;
      if (ev_q.size() == 0) begin
        miscompares++;
        $display("FAIL event @%0t: unexpected pulse qv=%b fe=%b q=%h, expected none",
                 $time, q_valid, frame_err, q);
      end else begin
        mon_ev = ev_q.pop_front();
        if (mon_ev.is_valid !== q_valid || mon_ev.is_valid === frame_err ||
            (mon_ev.is_valid && q !== mon_ev.data)) begin
          miscompares++;
          $display("FAIL event @%0t: got qv=%b fe=%b q=%h, expected %s q=%h",
                   $time, q_valid, frame_err, q,
                   mon_ev.is_valid ? "q_valid" : "frame_err", mon_ev.data);
        end
      end
    end
  end

  initial begin
    int kind;
    int len;
    logic [31:0] w;

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    send_bits(32'hA5, N, N-1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h3C, N, N-1);
    send_bits(32'hC3, N, N-1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h15, 5, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h2AB, 10, 9);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0F, 4, -1);
    send_bits(32'h81, N, N-1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h55, 3, -1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(32'hFF, N, N-1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    send_bits(32'h00, N, N-1);

    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 5);
      w    = $urandom;
      case (kind)
        0, 1: send_bits(w, N, N-1);
        2: begin len = $urandom_range(2, N-1); send_bits(w, len, len-1); end
        3: begin len = $urandom_range(N+1, N+3); send_bits(w, len, len-1); end
        4: send_bits(w, $urandom_range(1, N-1), -1);
        default: begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++)
            drive(1'b0, 1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
      endcase
    end

    for (int c = 0; c < 1500; c++)
      drive($urandom_range(0, 60) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 8) == 0, $urandom_range(0, 1) == 1);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    vectors++;
    if (ev_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected pulses never seen, required 0", ev_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
